// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and sizing constants for the 16x9 shift-add multiplier
package mult_pkg;
  typedef enum logic [2:0] {IDLE, INIT, ADD, SHIFT, DONE} mult_state_t;
  localparam int MULT_N = 9;
  localparam int MULT_CW = $clog2(MULT_N);
  localparam int MULT_PW = 25;
endpackage

// File: rtl/mult_bit_counter.sv
// mult_bit_counter: iteration counter (clk, rst, clr, inc -> cnt, last when cnt==N-1)
module mult_bit_counter #(
  parameter int N = 9,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign last = cnt == CW'(N - 1);
endmodule

// File: rtl/mult_controller.sv
// mult_controller: shift-add multiplier sequencer (CLK, RST, start, Q0 -> Acc/Q strobes, busy, done, bit_cnt)
module mult_controller
  import mult_pkg::*;
#(
  parameter int N = MULT_N,
  parameter int CW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          Q0,
  output logic          clear_Acc,
  output logic          load_Acc,
  output logic          shift_Acc,
  output logic          load_Q,
  output logic          shift_Q,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] bit_cnt
);
  mult_state_t state, next;
  logic last;
  mult_bit_counter #(.N(N), .CW(CW)) u_cnt (
    .clk  (CLK),
    .rst  (RST),
    .clr  (state == INIT),
    .inc  (state == SHIFT && !last),
    .cnt  (bit_cnt),
    .last (last)
  );
  always_ff @(posedge CLK) state <= RST ? IDLE : next;
  always_comb
    next = state == IDLE  ? (start ? INIT : IDLE) :
           state == INIT  ? ADD :
           state == ADD   ? SHIFT :
           state == SHIFT ? (last ? DONE : ADD) : IDLE;
  always_comb begin
    clear_Acc = state == INIT;
    load_Q    = state == INIT;
    load_Acc  = state == ADD && Q0;
    shift_Acc = state == SHIFT;
    shift_Q   = state == SHIFT;
    busy      = state == INIT || state == ADD || state == SHIFT;
    done      = state == DONE;
  end
endmodule

// File: tb/tb_mult_controller.sv
// tb_mult_controller: directed self-checking bench with a shift-add datapath model
module tb_mult_controller;
  import mult_pkg::*;
  localparam int N = MULT_N;
  localparam int CW = MULT_CW;
  logic CLK = 1'b0, RST = 1'b1, start = 1'b0, Q0 = 1'b0;
  logic clear_Acc, load_Acc, shift_Acc, load_Q, shift_Q, busy, done;
  logic [CW-1:0] bit_cnt;
  int n_tests = 0, n_fail = 0;
  int n_load, n_shift, n_shq, n_done, n_excl, cyc = 0;
  logic [15:0] mask, mc = '0;
  logic [16:0] acc = '0;
  logic [8:0] q = '0, opq = '0;
  mult_controller #(.N(N), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .Q0(Q0),
    .clear_Acc(clear_Acc), .load_Acc(load_Acc), .shift_Acc(shift_Acc),
    .load_Q(load_Q), .shift_Q(shift_Q), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );
  always #5 CLK = ~CLK;
  function automatic logic [6:0] outs();
    return {clear_Acc, load_Acc, shift_Acc, load_Q, shift_Q, busy, done};
  endfunction
  function automatic logic [31:0] product();
    logic [25:0] cat;
    cat = {acc, q};
    return 32'(cat[MULT_PW-1:0]);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr_tally();
    n_load = 0; n_shift = 0; n_shq = 0; n_done = 0; n_excl = 0; mask = '0;
  endtask
  task automatic step();
    logic [16:0] nacc;
    logic [8:0] nq;
    n_load += int'(load_Acc);
    n_shift += int'(shift_Acc);
    n_shq += int'(shift_Q);
    n_done += int'(done);
    if (int'(clear_Acc) + int'(load_Acc) + int'(shift_Acc) > 1) n_excl++;
    if (load_Acc) mask[bit_cnt] = 1'b1;
    nacc = acc;
    nq = q;
    if (clear_Acc) nacc = '0;
    if (load_Q) nq = opq;
    if (load_Acc) nacc = acc + {1'b0, mc};
    if (shift_Acc) {nacc, nq} = {acc, q} >> 1;
    @(posedge CLK);
    #1;
    acc = nacc;
    q = nq;
    Q0 = q[0];
    cyc++;
    @(negedge CLK);
  endtask
  task automatic run_op(input logic [8:0] qv, input logic [15:0] m, input logic [24:0] exp_p,
                        input bit poke, input string tag);
    opq = qv;
    mc = m;
    clr_tally();
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_init"}, 32'({clear_Acc, load_Q, busy, load_Acc, shift_Acc}), 32'b11100);
    for (int k = 1; k <= 2 * N; k++) begin
      start = poke && k == 8;
      step();
    end
    start = 1'b0;
    chk({tag, "_last_shift"}, 32'({shift_Acc, shift_Q, busy, bit_cnt}), 32'({3'b111, 4'd8}));
    step();
    chk({tag, "_done"}, 32'({outs(), bit_cnt}), 32'({7'b0000001, 4'd8}));
    start = poke;
    step();
    start = 1'b0;
    chk({tag, "_idle"}, 32'(outs()), 32'd0);
    step();
    chk({tag, "_idle2"}, 32'(outs()), 32'd0);
    chk({tag, "_loads"}, 32'(n_load), 32'($countones(qv)));
    chk({tag, "_load_bits"}, 32'(mask), 32'(qv));
    chk({tag, "_shifts"}, 32'({n_shift[15:0], n_shq[15:0]}), {16'd9, 16'd9});
    chk({tag, "_ndone"}, 32'(n_done), 32'd1);
    chk({tag, "_excl"}, 32'(n_excl), 32'd0);
    chk({tag, "_product"}, product(), 32'(exp_p));
  endtask
  initial begin
    int last_done;
    bit was_idle;
    repeat (3) step();
    chk("rst_hold", 32'({outs(), bit_cnt}), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", 32'({outs(), bit_cnt}), 32'd0);
    end
    run_op(9'h155, 16'hABCD, 25'hE4D811, 1'b0, "alt");
    run_op(9'h1FF, 16'hFFFF, 25'h1FEFE01, 1'b0, "ones");
    run_op(9'h000, 16'h1234, 25'h0, 1'b0, "zeros");
    opq = 9'h155;
    mc = 16'h0001;
    clr_tally();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("mid_add_bit4", 32'({busy, load_Acc, bit_cnt}), 32'({2'b11, 4'd4}));
    RST = 1'b1;
    step();
    chk("mid_rst", 32'({outs(), bit_cnt}), 32'd0);
    RST = 1'b0;
    repeat (3) step();
    chk("mid_rst_nodone", 32'({n_done[15:0], 9'd0, outs()}), 32'd0);
    run_op(9'h0A5, 16'h0003, 25'h1EF, 1'b0, "after_rst");
    run_op(9'h100, 16'h8001, 25'h800100, 1'b1, "poke");
    clr_tally();
    opq = 9'h155;
    mc = 16'hABCD;
    last_done = -1;
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      was_idle = outs() == 7'd0;
      step();
      if (was_idle) chk("b2b_init", 32'(clear_Acc), 32'd1);
      if (done) begin
        if (last_done >= 0) chk("b2b_period", 32'(cyc - last_done), 32'd21);
        last_done = cyc;
      end
    end
    start = 1'b0;
    repeat (25) step();
    chk("b2b_ndone", 32'(n_done), 32'd3);
    chk("b2b_end_idle", 32'(outs()), 32'd0);
    chk("b2b_excl", 32'(n_excl), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
